// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control slice:
// FSM state encoding, register-zero and NOP constants, and the load-use test.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALTED   = 2'b10
    } state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A load into r0 never creates a dependency, since r0 is never written.
    function automatic logic load_use(input logic       ex_mem_rd,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt,
                                      input logic       id_uses_rt);
        return ex_mem_rd && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with a synchronous clear; it holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr)
            r_count <= '0;
        else if (i_en && (r_count != {W{1'b1}}))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hold/flush control: load-use bubbles, taken-branch flush, data
// memory wait with timeout, external halt, and a stall-cycle counter.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rt,
    input  logic [4:0]       EX_rt,
    input  logic             EX_mem_rd,
    input  logic             branch_taken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    input  logic             halt_in,
    output logic             pc_wr,
    output logic             IF_ID_wr,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic             halted,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;
    logic       w_lu;
    logic       w_mem_stall;

    assign w_lu        = load_use(EX_mem_rd, EX_rt, ID_rs, ID_rt, ID_uses_rt);
    assign w_mem_stall = MEM_req && !MEM_ready;

    // Control outputs are combinational so a stall acts in the same cycle.
    always_comb begin
        pc_wr        = 1'b1;
        IF_ID_wr     = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        pipe_hold    = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            pc_wr        = 1'b0;
            IF_ID_wr     = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if ((r_state == ST_RUN && (halt_in || w_mem_stall)) ||
                        (r_state == ST_MEM_WAIT && !MEM_ready)) begin
                        pc_wr     = 1'b0;
                        IF_ID_wr  = 1'b0;
                        pipe_hold = 1'b1;
                    end else if (branch_taken) begin
                        // Wrong-path ID instruction: flush wins over load-use.
                        IF_ID_flush  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end else if (w_lu) begin
                        pc_wr        = 1'b0;
                        IF_ID_wr     = 1'b0;
                        ID_EX_bubble = 1'b1;
                    end
                end
                ST_HALTED: begin
                    pc_wr     = 1'b0;
                    IF_ID_wr  = 1'b0;
                    pipe_hold = 1'b1;
                    halted    = 1'b1;
                end
                default: begin
                    pc_wr     = 1'b0;
                    IF_ID_wr  = 1'b0;
                    pipe_hold = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt_in) begin
                        r_state <= ST_HALTED;
                    end else if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    // halt_in is deliberately not sampled while waiting on memory.
                    if (MEM_ready) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
                        r_state       <= ST_HALTED;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    assign state_o     = r_state;
    assign mem_timeout = r_mem_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_en    (!pc_wr),
        .o_count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios followed by
// randomized cycles, all compared against a cycle-level reference model.
module tb_hazard_stall_unit;

    localparam int TO = 4;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ID_rs, ID_rt, EX_rt;
    logic          ID_uses_rt, EX_mem_rd, branch_taken, MEM_req, MEM_ready, halt_in;
    logic          pc_wr, IF_ID_wr, IF_ID_flush, ID_EX_bubble, pipe_hold;
    logic          mem_timeout, halted;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_uses_rt   (ID_uses_rt),
        .EX_rt        (EX_rt),
        .EX_mem_rd    (EX_mem_rd),
        .branch_taken (branch_taken),
        .MEM_req      (MEM_req),
        .MEM_ready    (MEM_ready),
        .halt_in      (halt_in),
        .pc_wr        (pc_wr),
        .IF_ID_wr     (IF_ID_wr),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_bubble (ID_EX_bubble),
        .pipe_hold    (pipe_hold),
        .mem_timeout  (mem_timeout),
        .halted       (halted),
        .state_o      (state_o),
        .stall_cycles (stall_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 running, 1 waiting on memory, 2 stopped.
    int m_mode  = 0;
    int m_wait  = 0;
    int m_to    = 0;
    int m_stall = 0;

    // Control vector order: {pc_wr, IF_ID_wr, IF_ID_flush, ID_EX_bubble, pipe_hold, halted}
    function automatic logic [5:0] advance(input logic br, input logic lu);
        if (br)      return 6'b111100;
        else if (lu) return 6'b000100;
        else         return 6'b110000;
    endfunction

    task automatic cycle(input logic r, input logic h, input logic mreq, input logic mrdy,
                         input logic br, input logic ld, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        logic [5:0] exp_ctl;
        logic       lu;
        @(negedge clk);
        rst = r; halt_in = h; MEM_req = mreq; MEM_ready = mrdy; branch_taken = br;
        EX_mem_rd = ld; EX_rt = ert; ID_rs = rs; ID_rt = rt; ID_uses_rt = urt;
        #1;
        lu = ld && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        if (r)                         exp_ctl = 6'b001100;
        else if (m_mode == 2)          exp_ctl = 6'b000011;
        else if (m_mode == 0 && (h || (mreq && !mrdy))) exp_ctl = 6'b000010;
        else if (m_mode == 1 && !mrdy) exp_ctl = 6'b000010;
        else                           exp_ctl = advance(br, lu);

        check("ctl", {pc_wr, IF_ID_wr, IF_ID_flush, ID_EX_bubble, pipe_hold, halted}, exp_ctl);
        check("state", state_o, m_mode);
        check("timeout", mem_timeout, m_to);
        check("stall_cnt", stall_cycles, m_stall);

        if (r) begin
            m_mode = 0; m_wait = 0; m_to = 0; m_stall = 0;
        end else begin
            if (!exp_ctl[5] && m_stall < (1 << CW) - 1) m_stall++;
            if (m_mode == 0) begin
                if (h) m_mode = 2;
                else if (mreq && !mrdy) begin m_mode = 1; m_wait = 1; end
            end else if (m_mode == 1) begin
                if (mrdy) m_mode = 0;
                else if (m_wait == TO) begin m_to = 1; m_mode = 2; end
                else m_wait++;
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        rst = 1; halt_in = 0; MEM_req = 0; MEM_ready = 0; branch_taken = 0;
        EX_mem_rd = 0; EX_rt = 0; ID_rs = 0; ID_rt = 0; ID_uses_rt = 0;
        do_reset();
        do_reset();

        // Load-use stall then release.
        cycle(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        idle();
        check("lu_stall_total", stall_cycles, 1);

        // No false hazards: load to r0, and rt match with rt unused.
        cycle(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
        cycle(0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        check("no_false_pc", pc_wr, 1);
        check("no_false_total", stall_cycles, 1);

        // Branch overrides load-use.
        cycle(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        // Load-use through rt.
        cycle(0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1);

        // Memory wait: three not-ready cycles, then ready.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("memwait_state", state_o, 2'b00);
        check("memwait_total", stall_cycles, 3);

        // Timeout: entry cycle plus TO wait cycles, halt_in ignored while waiting.
        do_reset();
        cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < TO; i++) cycle(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("timeout_state", state_o, 2'b10);
        check("timeout_flag", mem_timeout, 1);
        check("timeout_halted", halted, 1);
        for (int i = 0; i < 3; i++) idle();
        do_reset();
        idle();
        check("post_rst_state", state_o, 2'b00);
        check("post_rst_flag", mem_timeout, 0);

        // Reset while waiting on memory.
        cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        do_reset();
        idle();
        check("rst_wait_state", state_o, 2'b00);

        // Halt from RUN, then long halt to reach counter saturation.
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("halt_state", state_o, 2'b10);
        for (int i = 0; i < 70; i++) idle();
        check("stall_saturated", stall_cycles, {CW{1'b1}});
        do_reset();
        idle();
        check("rst_halt_cnt", stall_cycles, 0);

        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 0,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
